// File: rtl/csa_tree_pkg.sv
// Shared sizing helpers for the carry-save reduction tree.
// Row counts, layer counts and pipeline depth derive from the tree shape.
package csa_tree_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int next_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_after(input int n, input int l);
    int r;
    r = n;
    for (int i = 0; i < l; i++) r = next_rows(r);
    return r;
  endfunction

  function automatic int num_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = next_rows(r);
      l++;
    end
    return l;
  endfunction

  function automatic int num_stages(input int levels, input int sl);
    return (levels + sl - 1) / sl;
  endfunction

  // Layer count after which pipeline stage k captures its rows
  function automatic int stage_end(input int k, input int sl,
                                   input int levels);
    return ((k + 1) * sl < levels) ? (k + 1) * sl : levels;
  endfunction

  localparam int DEF_NUM_OPS = 8;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_STAGE_L = 2;
  localparam int DEF_OUT_W   = DEF_WIDTH + clog2(DEF_NUM_OPS);
  localparam int DEF_LEVELS  = num_levels(DEF_NUM_OPS);
  localparam int DEF_PIPE    = num_stages(DEF_LEVELS, DEF_STAGE_L);

endpackage

// File: rtl/csa_fa_cell.sv
// Per-bit 3:2 compressor: sum and majority carry of three bits.
// Carry weight alignment is left to the instantiating layer.
module csa_fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_layer.sv
// One combinational 3:2 layer: triples become sum/carry pairs,
// leftover rows pass straight through.
module csa_layer
  import csa_tree_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int W    = 4,
  localparam int N_OUT = next_rows(N_IN)
) (
  input  logic [N_IN*W-1:0]  rows,
  output logic [N_OUT*W-1:0] res
);

  localparam int T = N_IN / 3;
  localparam int R = N_IN % 3;

  for (genvar t = 0; t < T; t++) begin : g_tri
    logic [W-1:0] maj;
    logic         unused_msb;
    for (genvar b = 0; b < W; b++) begin : g_bit
      csa_fa_cell u_fa (
        .a  (rows[(3*t)*W + b]),
        .b  (rows[(3*t+1)*W + b]),
        .c  (rows[(3*t+2)*W + b]),
        .s  (res[(2*t)*W + b]),
        .co (maj[b])
      );
    end
    // Carry out of the top bit falls outside the modular result
    assign res[(2*t+1)*W +: W] = {maj[W-2:0], 1'b0};
    assign unused_msb = maj[W-1];
  end

  for (genvar r = 0; r < R; r++) begin : g_pass
    assign res[(2*T+r)*W +: W] = rows[(3*T+r)*W +: W];
  end

endmodule

// File: rtl/csa_reduction_tree.sv
// Pipelined carry-save reduction of NUM_OPS rows to a sum/carry pair
// with an elastic valid/ready chain between register stages.
module csa_reduction_tree
  import csa_tree_pkg::*;
#(
  parameter int NUM_OPS      = 8,
  parameter int WIDTH        = 16,
  parameter int STAGE_LEVELS = 2,
  parameter int SIGNED       = 0,
  localparam int OUT_W = WIDTH + clog2(NUM_OPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] in_ops,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sum,
  output logic [OUT_W-1:0]         out_carry,
  output logic                     busy
);

  localparam int LEVELS = num_levels(NUM_OPS);
  localparam int PIPE   = num_stages(LEVELS, STAGE_LEVELS);
  localparam int BUS_W  = NUM_OPS * OUT_W;
  localparam int EXT    = OUT_W - WIDTH;

  logic [BUS_W-1:0] ext;
  logic [BUS_W-1:0] snext [PIPE];
  logic [BUS_W-1:0] sdata [PIPE];
  logic [PIPE-1:0]  v;
  logic [PIPE-1:0]  up;
  logic [PIPE:0]    rdy;
  logic             unused_top;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_ext
    logic [WIDTH-1:0] row;
    assign row = in_ops[i*WIDTH +: WIDTH];
    if (SIGNED != 0) begin : g_sx
      assign ext[i*OUT_W +: OUT_W] = {{EXT{row[WIDTH-1]}}, row};
    end else begin : g_zx
      assign ext[i*OUT_W +: OUT_W] = {{EXT{1'b0}}, row};
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N = rows_after(NUM_OPS, l);
    localparam int M = rows_after(NUM_OPS, l + 1);
    localparam int K = (l > 0) ? (l - 1) / STAGE_LEVELS : 0;
    logic [N*OUT_W-1:0] src;
    logic [M*OUT_W-1:0] res;
    if (l == 0) begin : g_in
      assign src = ext;
    end else if (stage_end(K, STAGE_LEVELS, LEVELS) == l) begin : g_reg
      logic unused_pad;
      assign src        = sdata[K][N*OUT_W-1:0];
      assign unused_pad = ^sdata[K][BUS_W-1:N*OUT_W];
    end else begin : g_comb
      assign src = g_lvl[l-1].res;
    end
    csa_layer #(.N_IN(N), .W(OUT_W)) u_layer (
      .rows (src),
      .res  (res)
    );
  end

  for (genvar k = 0; k < PIPE; k++) begin : g_stg
    localparam int E = stage_end(k, STAGE_LEVELS, LEVELS);
    localparam int M = rows_after(NUM_OPS, E);
    assign snext[k] = {{((NUM_OPS - M) * OUT_W){1'b0}}, g_lvl[E-1].res};
  end

  always_comb begin
    rdy       = '0;
    up        = '0;
    rdy[PIPE] = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) rdy[k] = !v[k] || rdy[k+1];
    up[0] = in_valid;
    for (int k = 1; k < PIPE; k++) up[k] = v[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < PIPE; k++) sdata[k] <= '0;
    end else begin
      for (int k = 0; k < PIPE; k++) begin
        if (flush) v[k] <= 1'b0;
        else if (rdy[k]) v[k] <= up[k];
        if (rdy[k] && up[k]) sdata[k] <= snext[k];
      end
    end
  end

  assign in_ready   = rdy[0];
  assign out_valid  = v[PIPE-1];
  assign out_sum    = sdata[PIPE-1][OUT_W-1:0];
  assign out_carry  = sdata[PIPE-1][2*OUT_W-1:OUT_W];
  assign busy       = |v;
  assign unused_top = ^sdata[PIPE-1][BUS_W-1:2*OUT_W];

endmodule

// File: tb/tb_csa_reduction_tree.sv
// Directed and scoreboard checks for the carry-save reduction tree,
// unsigned and sign-extending instances side by side.
module tb_csa_reduction_tree;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int OW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [N*W-1:0] in_ops = '0;

  logic          in_ready, out_valid, busy;
  logic [OW-1:0] out_sum, out_carry;
  logic          in_ready_s, out_valid_s, busy_s;
  logic [OW-1:0] out_sum_s, out_carry_s;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  bit sb_on  = 1'b0;
  logic [OW-1:0] q[$];

  typedef struct {
    logic [N*W-1:0] ops;
    logic [OW-1:0]  exp_u;
    logic [OW-1:0]  exp_s;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  csa_reduction_tree #(.NUM_OPS(N), .WIDTH(W), .STAGE_LEVELS(2),
                       .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .busy(busy)
  );

  csa_reduction_tree #(.NUM_OPS(N), .WIDTH(W), .STAGE_LEVELS(2),
                       .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_ops(in_ops),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_carry(out_carry_s), .busy(busy_s)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [N*W-1:0] ops,
                                          input bit sgn);
    logic [OW-1:0] acc;
    logic [W-1:0]  r;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      r = ops[i*W +: W];
      acc += sgn ? {{(OW-W){r[W-1]}}, r} : {{(OW-W){1'b0}}, r};
    end
    return acc;
  endfunction

  function automatic logic [N*W-1:0] rnd_ops();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin : mon
    logic [OW-1:0] e;
    if (sb_on) begin
      if (!rst_n) q.delete();
      else begin
        if (out_valid && out_ready) begin
          checks++;
          n_out++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got 0x%0h expected none",
                     OW'(out_sum + out_carry));
          end else begin
            e = q.pop_front();
            if (OW'(out_sum + out_carry) !== e) begin
              errors++;
              $display("FAIL sb_result: got 0x%0h expected 0x%0h",
                       OW'(out_sum + out_carry), e);
            end
          end
        end
        if (flush) q.delete();
        else if (in_valid && in_ready) q.push_back(model(in_ops, 1'b0));
      end
    end
  end

  task automatic run_vec(input vec_t t, input string tag);
    int lat;
    @(posedge clk); #1;
    in_ops = t.ops;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
    chk({tag, "_valid_s"}, 32'(out_valid_s), 32'd1);
    chk({tag, "_sum_u"}, 32'(OW'(out_sum + out_carry)), 32'(t.exp_u));
    chk({tag, "_sum_s"}, 32'(OW'(out_sum_s + out_carry_s)), 32'(t.exp_s));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (busy || q.size() != 0); i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] a;
    logic [N*W-1:0] tmp;
    logic [11:0]    hist;
    int             acc;

    tbl[0] = '{{N{16'hFFFF}}, 19'h7FFF8, 19'h7FFF8};
    tbl[1] = '{{{7{16'h0001}}, 16'h8000}, 19'h08007, 19'h78007};
    tbl[2] = '{'0, 19'h00000, 19'h00000};
    tmp = '0;
    for (int i = 0; i < N; i++) tmp[i*W +: W] = 16'(i);
    tbl[3] = '{tmp, 19'h0001C, 19'h0001C};
    tbl[4] = '{{N{16'h7FFF}}, 19'h3FFF8, 19'h3FFF8};
    tbl[5] = '{{N{16'h8000}}, 19'h40000, 19'h40000};
    tbl[6] = '{{112'd0, 16'h1234}, 19'h01234, 19'h01234};

    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    drain();

    // Backpressure: three offers against a stalled consumer
    sb_on = 1'b1;
    n_out = 0;
    a = rnd_ops();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_ops = a;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_ops = rnd_ops();
    @(negedge clk);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_ops = rnd_ops();
    @(negedge clk);
    chk("bp_ready2", 32'(in_ready), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_first", 32'(OW'(out_sum + out_carry)), 32'(model(a, 1'b0)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'(OW'(out_sum + out_carry)), 32'(model(a, 1'b0)));
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("bp_count", 32'(n_out), 32'd3);

    // Random streaming
    n_out = 0;
    acc = 0;
    for (int c = 0; c < 2000 && acc < 100; c++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_ops = rnd_ops();
      @(negedge clk);
      if (in_valid && in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    chk("stream_count", 32'(n_out), 32'd100);
    chk("stream_queue", 32'(q.size()), 32'd0);

    // Back-to-back burst: results must arrive without bubbles
    hist = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      in_valid = (c < 8);
      in_ops = rnd_ops();
      @(negedge clk);
      hist[c] = out_valid;
    end
    chk("burst_pattern", 32'(hist), 32'h3FC);
    drain();

    // Flush with two sets in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ops = rnd_ops();
    @(posedge clk); #1;
    in_ops = rnd_ops();
    @(posedge clk); #1;
    in_ops = rnd_ops();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("fl_no_result", 32'(out_valid), 32'd0);
    end

    // Flush drops an input offered in the same cycle
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_ops = rnd_ops();
    flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_drop_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a stream
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_ops = rnd_ops();
    end
    @(negedge clk);
    chk("rs_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_out_sum", 32'(out_sum), 32'd0);
    chk("rs_out_carry", 32'(out_carry), 32'd0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_vec(tbl[1], "rs_vec");
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
